// File: rtl/uart_frame_if.sv
// uart_frame_if: command, byte-TX, byte-RX and status signals of the UART frame initiator
//   master: the frame initiator (uart_frame_master)
//   slave : the requester plus the UART byte interface facing it
interface uart_frame_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_op;
    logic [127:0] cmd_payload;
    logic         cmd_expect_resp;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         busy;
    logic         done;
    logic [1:0]   status;
    logic [143:0] resp_data;
    logic [7:0]   stray_cnt;
    modport master (
        input  cmd_valid, cmd_op, cmd_payload, cmd_expect_resp, tx_ready, rx_data, rx_valid,
        output cmd_ready, tx_data, tx_valid, busy, done, status, resp_data, stray_cnt
    );
    modport slave (
        output cmd_valid, cmd_op, cmd_payload, cmd_expect_resp, tx_ready, rx_data, rx_valid,
        input  cmd_ready, tx_data, tx_valid, busy, done, status, resp_data, stray_cnt
    );
endinterface

// File: rtl/uart_frame_master.sv
// uart_frame_master: sends one 18-byte {op, payload, op} frame and optionally collects an 18-byte response
//   clk, reset : system clock, synchronous active-high reset
//   bus        : cmd_* request, tx_* byte out, rx_* byte in, busy/done/status/resp_data/stray_cnt
module uart_frame_master #(
    parameter int FRAME_BYTES    = 18,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic          clk,
    input logic          reset,
    uart_frame_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0] LAST = 5'(FRAME_BYTES - 1);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, DONE} state_t;
    state_t        state;
    logic [143:0]  sh;
    logic [4:0]    cnt;
    logic [TW-1:0] timer;
    logic          expect_resp;
    // the shift register empties to zero as it drains, so tx_data reads 0 whenever idle
    assign bus.tx_data = sh[143:136];
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            sh            <= '0;
            cnt           <= '0;
            timer         <= '0;
            expect_resp   <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.tx_valid  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.status    <= 2'b00;
            bus.resp_data <= '0;
            bus.stray_cnt <= '0;
        end else begin
            bus.done <= 1'b0;
            if (bus.rx_valid && state != WAIT_RESP && bus.stray_cnt != 8'hff)
                bus.stray_cnt <= bus.stray_cnt + 8'd1;
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    sh            <= {bus.cmd_op, bus.cmd_payload, bus.cmd_op};
                    cnt           <= '0;
                    expect_resp   <= bus.cmd_expect_resp;
                    bus.cmd_ready <= 1'b0;
                    bus.busy      <= 1'b1;
                    bus.tx_valid  <= 1'b1;
                    state         <= SEND;
                end
                SEND: if (bus.tx_ready) begin
                    sh  <= sh << 8;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        bus.tx_valid <= 1'b0;
                        cnt          <= '0;
                        timer        <= '0;
                        if (expect_resp) begin
                            bus.resp_data <= '0;
                            state         <= WAIT_RESP;
                        end else begin
                            bus.status <= 2'b00;
                            bus.done   <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                WAIT_RESP: begin
                    // a byte arriving on the timeout cycle wins over the timeout
                    if (bus.rx_valid) begin
                        bus.resp_data <= {bus.resp_data[135:0], bus.rx_data};
                        cnt           <= cnt + 5'd1;
                        timer         <= '0;
                        if (cnt == LAST) begin
                            // resp_data[135:128] becomes the first byte after this shift
                            bus.status <= (bus.resp_data[135:128] == bus.rx_data) ? 2'b01 : 2'b10;
                            bus.done   <= 1'b1;
                            state      <= DONE;
                        end
                    end else if (timer == T_LAST) begin
                        bus.status <= 2'b11;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DONE: begin
                    bus.cmd_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_master.sv
// tb_uart_frame_master: randomized self-checking bench for uart_frame_master against a frame-level model
module tb_uart_frame_master;
    localparam int TO = 100;
    logic clk = 1'b0;
    logic reset = 1'b1;
    uart_frame_if bus ();
    uart_frame_master #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int dones = 0;
    int done_cyc = 0;
    int rdy_mode = 0;
    int exp_stray = 0;
    logic [7:0]   txq[$];
    logic [7:0]   rxb[18];
    logic [143:0] exp_resp = '0;
    logic         stall_prev = 1'b0;
    logic [7:0]   prev_data = '0;
    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: bus.tx_ready = 1'b1;
            1: bus.tx_ready = ~bus.tx_ready;
            default: bus.tx_ready = 1'($urandom);
        endcase
    end
    always @(negedge clk) begin
        if (!reset) begin
            if (stall_prev && bus.tx_valid) check("tx_hold", 144'(bus.tx_data), 144'(prev_data));
            if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
            if (bus.done) begin
                dones++;
                done_cyc = cyc;
            end
        end
        stall_prev = bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
    end
    task automatic run_cmd(input logic [7:0] op, input logic [127:0] pl, input logic ex, input int nrx, input int mode);
        logic [143:0] got;
        logic [1:0]   exp_st;
        int acc, lastrx, t;
        got = '0;
        lastrx = 0;
        t = 0;
        rdy_mode = mode;
        txq.delete();
        dones = 0;
        while (!bus.cmd_ready && t < 100) begin @(posedge clk); #1; t++; end
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_payload = pl;
        bus.cmd_expect_resp = ex;
        @(posedge clk); #1;
        acc = cyc;
        bus.cmd_op = ~op;
        bus.cmd_payload = ~pl;
        bus.cmd_expect_resp = ~ex;
        check("accept_txv", 144'(bus.tx_valid), 144'(1));
        check("accept_busy", 144'(bus.busy), 144'(1));
        check("accept_ready", 144'(bus.cmd_ready), 144'(0));
        repeat (3) begin @(posedge clk); #1; end
        bus.cmd_valid = 1'b0;
        t = 0;
        while (txq.size() < 18 && t < 1000) begin @(posedge clk); #1; t++; end
        if (ex) for (int i = 0; i < nrx; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            bus.rx_valid = 1'b1;
            bus.rx_data = rxb[i];
            lastrx = cyc;
            @(posedge clk); #1;
            bus.rx_valid = 1'b0;
        end
        t = 0;
        while (dones == 0 && t < 400) begin @(posedge clk); #1; t++; end
        check("done_pulse", 144'(dones), 144'(1));
        check("done_single", 144'(bus.done), 144'(0));
        check("ready_after", 144'(bus.cmd_ready), 144'(1));
        check("busy_after", 144'(bus.busy), 144'(0));
        check("tx_count", 144'(txq.size()), 144'(18));
        for (int i = 0; i < txq.size() && i < 18; i++) got = {got[135:0], txq[i]};
        check("tx_frame", got, {op, pl, op});
        if (!ex && mode == 0) check("send_lat", 144'(done_cyc - acc), 144'(18));
        if (ex && nrx == 18) check("resp_lat", 144'(done_cyc - lastrx), 144'(1));
        if (ex && nrx > 0 && nrx < 18) check("timeout_lat", 144'(done_cyc - lastrx), 144'(TO + 1));
        exp_st = !ex ? 2'b00 : (nrx < 18) ? 2'b11 : (rxb[0] == rxb[17]) ? 2'b01 : 2'b10;
        if (ex) begin
            exp_resp = '0;
            for (int i = 0; i < nrx; i++) exp_resp = {exp_resp[135:0], rxb[i]};
        end
        check("status", 144'(bus.status), 144'(exp_st));
        check("resp_data", bus.resp_data, exp_resp);
        check("stray_hold", 144'(bus.stray_cnt), 144'(exp_stray));
    endtask
    task automatic stray_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data = 8'($urandom);
            @(posedge clk); #1;
            bus.rx_valid = 1'b0;
            exp_stray = (exp_stray < 255) ? exp_stray + 1 : 255;
        end
    endtask
    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [143:0] s;
        int t;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_payload = '0;
        bus.cmd_expect_resp = 1'b0;
        bus.tx_ready = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 144'(bus.cmd_ready), 144'(1));
        check("rst_txv", 144'(bus.tx_valid), 144'(0));
        check("rst_txd", 144'(bus.tx_data), 144'(0));
        check("rst_busy", 144'(bus.busy), 144'(0));
        check("rst_done", 144'(bus.done), 144'(0));
        check("rst_status", 144'(bus.status), 144'(0));
        check("rst_resp", bus.resp_data, 144'(0));
        check("rst_stray", 144'(bus.stray_cnt), 144'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        stray_pulses(3);
        check("stray3", 144'(bus.stray_cnt), 144'(exp_stray));
        run_cmd("C", 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 0, 0);
        run_cmd("C", 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 0, 1);
        rxb[0] = "B";
        for (int i = 1; i < 17; i++) rxb[i] = 8'hAA;
        rxb[17] = "B";
        run_cmd("B", {4{$urandom}}, 1'b1, 18, 2);
        s = "123456789012345678";
        for (int i = 0; i < 18; i++) rxb[i] = s[143-8*i -: 8];
        run_cmd("A", {4{$urandom}}, 1'b1, 18, 0);
        for (int i = 0; i < 18; i++) rxb[i] = 8'($urandom);
        run_cmd(8'($urandom), {4{$urandom}}, 1'b1, 5, 0);
        for (int k = 0; k < 8; k++) begin
            int r, n;
            logic ex;
            ex = 1'($urandom);
            r = $urandom_range(0, 3);
            n = (r == 0) ? $urandom_range(1, 17) : 18;
            for (int i = 0; i < 18; i++) rxb[i] = 8'($urandom);
            if (r == 1) rxb[17] = rxb[0];
            run_cmd(8'($urandom), {4{$urandom}}, ex, n, $urandom_range(0, 2));
        end
        stray_pulses(260);
        check("stray_sat", 144'(bus.stray_cnt), 144'(exp_stray));
        rdy_mode = 0;
        txq.delete();
        dones = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = "D";
        bus.cmd_payload = {4{$urandom}};
        bus.cmd_expect_resp = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        t = 0;
        while (txq.size() < 7 && t < 100) begin @(posedge clk); #1; t++; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_resp = '0;
        exp_stray = 0;
        check("mid_txv", 144'(bus.tx_valid), 144'(0));
        check("mid_txd", 144'(bus.tx_data), 144'(0));
        check("mid_ready", 144'(bus.cmd_ready), 144'(1));
        check("mid_busy", 144'(bus.busy), 144'(0));
        check("mid_status", 144'(bus.status), 144'(0));
        check("mid_resp", bus.resp_data, 144'(0));
        check("mid_stray", 144'(bus.stray_cnt), 144'(0));
        repeat (30) begin @(posedge clk); #1; end
        check("mid_no_done", 144'(dones), 144'(0));
        run_cmd("E", {4{$urandom}}, 1'b0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
